mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// - Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
// - Sequences multi-byte transfers one byte per cycle and returns assembled little-endian words.
// - if_done/if_inst feed the IF stage, which produces get_inst/if_inst for the IF/ID register.
// - MEM-stage loads/stores have priority; a starvation counter guarantees IF forward progress.
// PARAMETERS
// - ADDR_WIDTH   32  width of all byte addresses
// - STARVE_LIMIT 8   consecutive MEM grants with if_req pending before IF is forced; 0 = MEM always wins
// PORTS
// - clk           in   1           clock, all state updates on rising edge
// - rst           in   1           reset, synchronous, active-low
// - if_req        in   1           IF requests 4-byte read; level, held until if_done or flush
// - if_addr       in   ADDR_WIDTH  fetch byte address
// - if_flush      in   1           branch/jump flush; aborts pending/active IF read
// - if_done       out  1           one-cycle pulse, if_inst valid
// - if_inst       out  32          fetched word, byte0 in [7:0]
// - mem_req       in   1           MEM stage request; level, held until mem_done
// - mem_wr        in   1           1 = store, 0 = load
// - mem_addr      in   ADDR_WIDTH  first byte address
// - mem_len       in   3           byte count: 1, 2 or 4
// - mem_wdata     in   32          store data, byte0 in [7:0]
// - mem_done      out  1           one-cycle pulse; mem_rdata valid for loads
// - mem_rdata     out  32          load data, zero-extended
// - ram_addr      out  ADDR_WIDTH  RAM byte address (registered)
// - ram_wr        out  1           RAM write strobe (registered)
// - ram_dout      out  8           RAM write data (registered)
// - ram_din       in   8           RAM read data, valid the cycle after ram_addr
// - busy          out  1           high in any state other than IDLE
// - perf_if_wait  out  32          IF wait-cycle counter (see CONFIGURATION)
// - perf_mem_wait out  32          MEM wait-cycle counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: sampled at a rising edge with rst=0 -> IDLE, counters cleared.
//   - All outputs are 0 in the following cycle, including ram_wr.
//   - Reset mid-transfer aborts with no done pulse.
// - States: IDLE, IF_RD, MEM_RD, MEM_WR. The grant decision is made only in IDLE.
//   - Only mem_req: MEM. Only if_req (and no if_flush): IF.
//   - Both pending: MEM, unless starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0, then IF.
// - Starvation counter:
//   - starve_cnt increments on each MEM grant while if_req=1.
//   - Cleared on an IF grant or whenever if_req=0.
//   - Saturates at STARVE_LIMIT.
// - Addresses and data are latched at grant; later changes to requester inputs are ignored.
// - Read of N bytes (grant edge ends cycle 0):
//   - Cycles 1..N: ram_addr = base+k.
//   - Byte k is captured from ram_din in cycle k+2.
//   - done pulses in cycle N+2, with data valid in the same cycle.
//   - State is IDLE during the done cycle, so a new grant can be sampled at the end of it.
// - Write of N bytes: cycles 1..N drive ram_wr=1, ram_addr=base+k, ram_dout=mem_wdata[8k+7:8k].
//   - mem_done pulses in cycle N+1; ram_wr=0 at all other times.
// - Address arithmetic is modulo 2^ADDR_WIDTH: base all-ones, byte 1 -> address 0.
// - mem_len values other than 1 or 2 are treated as 4.
// - if_flush:
//   - In IF_RD: next state is IDLE, no if_done, partial data discarded.
//   - In IDLE with if_req: no IF grant that cycle.
//   - Has no effect on MEM transfers.
// - if_inst and mem_rdata hold their last value between done pulses.
// CONFIGURATION
// - MEM_ARB_PERF_EN defined:
//   - perf_if_wait counts cycles with if_req=1 while not in IF_RD.
//   - perf_mem_wait counts cycles with mem_req=1 while not in MEM_RD/MEM_WR.
//   - Both saturate at 32'hFFFFFFFF and are cleared by reset.
// - MEM_ARB_PERF_EN undefined: counters are not built; both ports are tied to 0.
// TESTING
// - IF only, if_addr=0x100, RAM bytes 13,00,50,00 -> ram_addr 0x100..0x103 in cycles 1-4;
//   if_done in cycle 6 with if_inst=0x00500013.
// - MEM store, len=2, addr=0x20, wdata=0xAABBCCDD -> ram_wr=1 in cycles 1-2 writing DD@0x20,
//   CC@0x21; mem_done in cycle 3.
// - if_req and mem_req (load, len=1) raised together -> MEM granted first;
//   IF granted in the mem_done cycle; both done pulses occur exactly once.
// - STARVE_LIMIT=2, if_req held with back-to-back MEM loads -> third grant goes to IF.
// - if_flush in cycle 3 of IF_RD -> IDLE next cycle, no if_done; a new if_req is granted normally.
// - rst=0 during a MEM_WR -> ram_wr=0 the next cycle, no mem_done;
//   with MEM_ARB_PERF_EN, counters read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the MEM stage. Multi-byte transfers run one byte per cycle. The arbiter
// returns little-endian words. MEM has priority, and a starvation counter
// forces an IF grant after STARVE_LIMIT consecutive MEM wins.
// Optional feature: define MEM_ARB_PERF_EN to build the wait-cycle counters.
// When it is undefined, both perf ports are tied to zero.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  input  logic                  mem_req_i,
  input  logic                  mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [2:0]            mem_len_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i,
  output logic                  busy_o,
  output logic [31:0]           perf_if_wait_o,
  output logic [31:0]           perf_mem_wait_o
);

  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         starve_q;
  logic [2:0]            cnt_q;
  logic [2:0]            len_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_wr_q;
  logic [7:0]            ram_dout_q;
  logic                  if_done_q, mem_done_q;
  logic [31:0]           if_inst_q, mem_rdata_q;
  logic                  busy;

  logic                  if_pend, force_if, grant_if, grant_mem;
  logic                  rd_state, rd_last, wr_last;
  logic [2:0]            mem_len_dec;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Grant decision; a flushing IF request is not eligible this cycle
  always_comb begin
    if_pend   = if_req_i & ~if_flush_i;
    force_if  = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
    grant_mem = (state_q == IDLE) & mem_req_i & ~(if_pend & force_if);
    grant_if  = (state_q == IDLE) & if_pend & (~mem_req_i | force_if);
    case (mem_len_i)
      3'd1:    mem_len_dec = 3'd1;
      3'd2:    mem_len_dec = 3'd2;
      default: mem_len_dec = 3'd4;
    endcase
    rd_state  = (state_q == IF_RD) || (state_q == MEM_RD);
    rd_last   = rd_state && (cnt_q == len_q + 3'd1);
    wr_last   = (state_q == MEM_WR) && (cnt_q == len_q);
    addr_next = base_q + ADDR_WIDTH'(cnt_q);
  end

  // Merge the byte arriving this cycle into the assembly word
  always_comb begin
    asm_d = asm_q;
    case (cnt_q)
      3'd2:    asm_d[7:0]   = ram_din_i;
      3'd3:    asm_d[15:8]  = ram_din_i;
      3'd4:    asm_d[23:16] = ram_din_i;
      3'd5:    asm_d[31:24] = ram_din_i;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; read states linger one extra cycle for RAM latency
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_mem)     state_d = mem_wr_i ? MEM_WR : MEM_RD;
               else if (grant_if) state_d = IF_RD;
      IF_RD:   if (if_flush_i || rd_last) state_d = IDLE;
      MEM_RD:  if (rd_last) state_d = IDLE;
      MEM_WR:  if (wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Starvation counter: counts MEM wins over a waiting IF, saturating
  always_ff @(posedge clk_i) begin
    if (!rst_i)                     starve_q <= '0;
    else if (!if_req_i || grant_if) starve_q <= '0;
    else if (grant_mem && starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
  end

  // Transfer parameters latched at grant; only meaningful outside IDLE
  always_ff @(posedge clk_i) begin
    if (grant_mem || grant_if) begin
      base_q  <= grant_mem ? mem_addr_i : if_addr_i;
      len_q   <= grant_mem ? mem_len_dec : 3'd4;
      wdata_q <= mem_wdata_i;
      asm_q   <= '0;
    end else if (rd_state && cnt_q >= 3'd2) begin
      asm_q   <= asm_d;
    end
  end

  // Byte sequencing, RAM port drive and done pulses
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (grant_mem || grant_if) begin
        cnt_q      <= 3'd1;
        ram_addr_q <= grant_mem ? mem_addr_i : if_addr_i;
        ram_wr_q   <= grant_mem & mem_wr_i;
        ram_dout_q <= mem_wdata_i[7:0];
      end else if (rd_state) begin
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q < len_q) ram_addr_q <= addr_next;
        if (rd_last) begin
          if (state_q == MEM_RD) begin
            mem_rdata_q <= asm_d;
            mem_done_q  <= 1'b1;
          end else if (!if_flush_i) begin
            if_inst_q   <= asm_d;
            if_done_q   <= 1'b1;
          end
        end
      end else if (state_q == MEM_WR) begin
        cnt_q <= cnt_q + 3'd1;
        if (wr_last) begin
          ram_wr_q   <= 1'b0;
          mem_done_q <= 1'b1;
        end else begin
          ram_addr_q <= addr_next;
          ram_dout_q <= 8'(wdata_q >> {cnt_q[1:0], 3'b000});
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_mem_q;

  // Saturating counts of cycles each requester spends waiting
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_if_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      if (if_req_i && state_q != IF_RD && perf_if_q != 32'hFFFF_FFFF)
        perf_if_q <= perf_if_q + 32'd1;
      if (mem_req_i && state_q != MEM_RD && state_q != MEM_WR && perf_mem_q != 32'hFFFF_FFFF)
        perf_mem_q <= perf_mem_q + 32'd1;
    end
  end

  assign perf_if_wait_o  = perf_if_q;
  assign perf_mem_wait_o = perf_mem_q;
`else
  assign perf_if_wait_o  = '0;
  assign perf_mem_wait_o = '0;
`endif

  assign if_done_o   = if_done_q;
  assign if_inst_o   = if_inst_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_dout_o  = ram_dout_q;
  assign busy_o      = busy;

endmodule
